// File: rtl/rf_pkg.sv
// Shared register-file types and decode-stage default sizing.
package rf_pkg;

  typedef enum logic {
    INIT,
    RUN
  } rf_state_e;

  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_INDEX = 1;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;

endpackage

// File: rtl/reg_file_nport_read_port.sv
// One registered read port: zero-register check, same-cycle write bypass, output flop.
module rf_read_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  always_comb begin
    rd_d = '0;
    if (run) begin
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_d = '0;
      end else if (wr_en && (wr_addr == rd_addr)) begin
        rd_d = wr_data;
      end else begin
        rd_d = mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/reg_file_nport.sv
// N-read/1-write register file with reset sweep, write bypass and optional zero register.
module reg_file_nport
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W,
  parameter int unsigned ADDR_W    = RF_ADDR_W,
  parameter int unsigned NUM_RD    = RF_NUM_RD,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned INIT_MODE = INIT_INDEX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        WR,
  input  logic [DATA_W-1:0]        WD,
  input  logic [NUM_RD*ADDR_W-1:0] PR,
  output logic [NUM_RD*DATA_W-1:0] RD,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              run;
  logic              user_we;

  function automatic logic [DATA_W-1:0] fill_value(input logic [ADDR_W-1:0] idx);
    return (INIT_MODE == INIT_INDEX) ? DATA_W'(idx) : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // The reset edge itself seeds entry 0; the sweep then rewrites it at the first INIT edge.
  always_comb begin
    run     = (state_q == RUN);
    ready   = run;
    user_we = run && write && !((ZERO_REG != 0) && (WR == '0));
    mem_we  = 1'b0;
    mem_wa  = '0;
    mem_wd  = '0;
    if (reset) begin
      mem_we = 1'b1;
      mem_wa = '0;
      mem_wd = fill_value('0);
    end else if (state_q == INIT) begin
      mem_we = 1'b1;
      mem_wa = idx_q;
      mem_wd = fill_value(idx_q);
    end else if (user_we) begin
      mem_we = 1'b1;
      mem_wa = WR;
      mem_wd = WD;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .rd_addr (PR[k*ADDR_W +: ADDR_W]),
      .mem_data(mem_q[PR[k*ADDR_W +: ADDR_W]]),
      .wr_en   (write),
      .wr_addr (WR),
      .wr_data (WD),
      .rd_data (RD[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_nport.sv
// Bench for reg_file_nport: default, ZERO_REG=0 and small-geometry instances.
module tb_reg_file_nport;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [9:0]  pr;
  logic [63:0] rd_a, rd_z;
  logic        ready_a, ready_z;

  logic        write_c;
  logic [2:0]  wr_c;
  logic [15:0] wd_c;
  logic [8:0]  pr_c;
  logic [47:0] rd_c;
  logic        ready_c;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  reg_file_nport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .INIT_MODE(1)
  ) u_a (
    .clk(clk), .reset(reset), .write(write), .WR(wr), .WD(wd),
    .PR(pr), .RD(rd_a), .ready(ready_a)
  );

  reg_file_nport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .INIT_MODE(1)
  ) u_z (
    .clk(clk), .reset(reset), .write(write), .WR(wr), .WD(wd),
    .PR(pr), .RD(rd_z), .ready(ready_z)
  );

  reg_file_nport #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0), .INIT_MODE(0)
  ) u_c (
    .clk(clk), .reset(reset), .write(write_c), .WR(wr_c), .WD(wd_c),
    .PR(pr_c), .RD(rd_c), .ready(ready_c)
  );

  typedef struct {
    logic        write;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  pr0;
    logic [4:0]  pr1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  typedef struct {
    logic [31:0] a0, a1, z0, z1;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] zmem [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) zmem[i] = 32'(i);
  endtask

  // Steps until u_a is ready, checking sweep lengths and that reads stay zero during the sweep.
  task automatic wait_ready();
    int unsigned na = 0, nc = 0;
    logic        nonzero = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ready_c && nc == 0) nc = n;
      if (ready_a) begin
        na = n;
        break;
      end
      if (rd_a != '0 || rd_z != '0 || ready_z) nonzero = 1'b1;
    end
    check("sweep_len_a", na, 32);
    check("sweep_len_c", nc, 8);
    check("rd_zero_in_init", {31'd0, nonzero}, 0);
    check("ready_z_after_sweep", {31'd0, ready_z}, 1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_a_rd0"}, rd_a[31:0],  e.a0);
    check({tag, "_a_rd1"}, rd_a[63:32], e.a1);
    check({tag, "_z_rd0"}, rd_z[31:0],  e.z0);
    check({tag, "_z_rd1"}, rd_z[63:32], e.z1);
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] p0, input logic [4:0] p1,
                       input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    write = w; wr = a; wd = d; pr = {p1, p0};
    e.a0 = e0;
    e.a1 = e1;
    e.z0 = (w && a == p0) ? d : zmem[p0];
    e.z1 = (w && a == p1) ? d : zmem[p1];
    if (w) zmem[a] = d;
    exp_q.push_back(e);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'd0,          5'd6,  5'd8,  32'd6,  32'd8};
    vecs[1]  = '{1'b1, 5'd4,  32'd31,         5'd0,  5'd3,  32'd0,  32'd3};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,          5'd4,  5'd5,  32'd31, 32'd5};
    vecs[3]  = '{1'b1, 5'd1,  32'd20,         5'd1,  5'd1,  32'd20, 32'd20};
    vecs[4]  = '{1'b0, 5'd0,  32'd0,          5'd1,  5'd4,  32'd20, 32'd31};
    vecs[5]  = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd2,  32'd0,  32'd2};
    vecs[6]  = '{1'b0, 5'd0,  32'd0,          5'd0,  5'd0,  32'd0,  32'd0};
    vecs[7]  = '{1'b1, 5'd10, 32'd99,         5'd10, 5'd31, 32'd99, 32'd31};
    vecs[8]  = '{1'b1, 5'd31, 32'd7,          5'd30, 5'd31, 32'd30, 32'd7};
    vecs[9]  = '{1'b0, 5'd0,  32'd0,          5'd10, 5'd31, 32'd99, 32'd7};
    vecs[10] = '{1'b1, 5'd4,  32'd55,         5'd4,  5'd4,  32'd55, 32'd55};
    vecs[11] = '{1'b0, 5'd0,  32'd0,          5'd4,  5'd0,  32'd55, 32'd0};

    reset = 1'b1; write = 1'b0; wr = '0; wd = '0; pr = '0;
    write_c = 1'b0; wr_c = '0; wd_c = '0; pr_c = '0;
    step();
    check("reset_ready_a", {31'd0, ready_a}, 0);
    check("reset_rd_a0", rd_a[31:0], 0);
    check("reset_rd_a1", rd_a[63:32], 0);
    check("reset_rd_c", {16'd0, rd_c[15:0]}, 0);

    reset = 1'b0;
    wait_ready();
    model_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].write, vecs[i].wr, vecs[i].wd, vecs[i].pr0, vecs[i].pr1,
            vecs[i].exp0, vecs[i].exp1);
      step();
      check("ready_run", {31'd0, ready_a}, 1);
      pop_compare($sformatf("vec%0d", i));
    end

    // Reset in RUN with a write in flight, then again partway through the sweep.
    write = 1'b1; wr = 5'd3; wd = 32'd123; pr = {5'd10, 5'd10};
    reset = 1'b1;
    step();
    check("rst_run_ready", {31'd0, ready_a}, 0);
    check("rst_run_rd", rd_a[31:0], 0);
    reset = 1'b0;
    wr = 5'd5; wd = 32'd77;
    for (int i = 0; i < 15; i++) step();
    check("mid_sweep_ready", {31'd0, ready_a}, 0);
    reset = 1'b1; wr = 5'd3;
    step();
    reset = 1'b0; wr = 5'd5;
    wait_ready();
    model_reset();

    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd3, 32'd10, 32'd3);
    step();
    pop_compare("post_rst_10_3");
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 32'd5, 32'd0);
    step();
    pop_compare("post_rst_5_0");
    check("queue_drained", exp_q.size(), 0);

    // Small geometry: zero-filled, three independent ports.
    write_c = 1'b0; pr_c = {3'd7, 3'd5, 3'd1};
    step();
    check("c_init0_p0", {16'd0, rd_c[15:0]},  0);
    check("c_init0_p1", {16'd0, rd_c[31:16]}, 0);
    check("c_init0_p2", {16'd0, rd_c[47:32]}, 0);
    write_c = 1'b1; wr_c = 3'd2; wd_c = 16'h1111;
    step();
    write_c = 1'b1; wr_c = 3'd5; wd_c = 16'h2222; pr_c = {3'd7, 3'd5, 3'd2};
    step();
    check("c_p0_mem",    {16'd0, rd_c[15:0]},  32'h1111);
    check("c_p1_bypass", {16'd0, rd_c[31:16]}, 32'h2222);
    check("c_p2_zero",   {16'd0, rd_c[47:32]}, 0);
    write_c = 1'b1; wr_c = 3'd0; wd_c = 16'h0F0F; pr_c = {3'd0, 3'd5, 3'd0};
    step();
    check("c_p0_wr0_bypass", {16'd0, rd_c[15:0]},  32'h0F0F);
    check("c_p1_mem",        {16'd0, rd_c[31:16]}, 32'h2222);
    check("c_p2_wr0_bypass", {16'd0, rd_c[47:32]}, 32'h0F0F);
    write_c = 1'b0; pr_c = {3'd2, 3'd7, 3'd0};
    step();
    check("c_p0_entry0", {16'd0, rd_c[15:0]},  32'h0F0F);
    check("c_p1_entry7", {16'd0, rd_c[31:16]}, 0);
    check("c_p2_entry2", {16'd0, rd_c[47:32]}, 32'h1111);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
